audio_playback_ctrl: RTL

Playback sequencer for the flash-based audio player. It steps a 32-bit word address through flash using a read/waitrequest/readdatavalid handshake, splits each word into two signed 16-bit samples, and releases one sample per `sample_tick` to the audio codec path. It applies play/pause, direction, restart and address wrap-around, and flags ticks that arrive before a sample is ready.

---
 rtl/ipod_pkg.sv | 20 ++
 rtl/tick_latch.sv | 42 ++++
 rtl/audio_playback_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ipod_pkg.sv
// Shared constants for the flash audio player: FSM encodings, sample/word widths and
// the default clip bounds used by the playback and keyboard/direction control logic.
package ipod_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned WORD_W   = 32;

  localparam logic [20:0] DEFAULT_START_ADDR = 21'h00000;
  localparam logic [20:0] DEFAULT_END_ADDR   = 21'h7FFFF;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StReq      = 3'd1;
  localparam logic [2:0] StWaitData = 3'd2;
  localparam logic [2:0] StWaitT0   = 3'd3;
  localparam logic [2:0] StOut0     = 3'd4;
  localparam logic [2:0] StWaitT1   = 3'd5;
  localparam logic [2:0] StOut1     = 3'd6;
  localparam logic [2:0] StAdvance  = 3'd7;

endpackage

// File: rtl/tick_latch.sv
// One-deep pending flag for sample ticks, with sticky underrun when a tick arrives
// before the previous one has been consumed.
module tick_latch (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic play_i,
  input  logic consume_i,
  input  logic clear_i,
  output logic pending_o,
  output logic underrun_o
);

  logic pending_q, pending_d;
  logic underrun_q, underrun_d;
  logic tick_live;

  // Ticks while paused are discarded outright.
  assign tick_live = tick_i & play_i;

  always_comb begin
    pending_d  = (pending_q & ~consume_i) | tick_live;
    underrun_d = underrun_q | (tick_live & pending_q & ~consume_i);
    if (clear_i) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      underrun_q <= underrun_d;
    end
  end

  assign pending_o  = pending_q;
  assign underrun_o = underrun_q;

endmodule

// File: rtl/audio_playback_ctrl.sv
// Playback sequencer: fetches 32-bit words from flash, emits two 16-bit samples per
// word on sample ticks, and steps the word address forward/backward with wrap-around.
module audio_playback_ctrl
  import ipod_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 21,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(DEFAULT_START_ADDR),
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(DEFAULT_END_ADDR)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                play_i,
  input  logic                dir_i,
  input  logic                restart_i,
  input  logic                sample_tick_i,
  output logic [ADDR_W-1:0]   flash_addr_o,
  output logic                flash_read_o,
  input  logic                flash_waitrequest_i,
  input  logic                flash_readdatavalid_i,
  input  logic [WORD_W-1:0]   flash_readdata_i,
  output logic [SAMPLE_W-1:0] audio_out_o,
  output logic                audio_valid_o,
  output logic                underrun_o,
  output logic [2:0]          state_dbg_o
);

  logic [2:0]          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                wdir_q, wdir_d;
  logic                restart_pend_q, restart_pend_d;
  logic                flash_read_q;
  logic [SAMPLE_W-1:0] audio_q, audio_d;
  logic                audio_valid_q, audio_valid_d;
  logic                tick_pending;
  logic                consume;
  logic [ADDR_W-1:0]   restart_addr;

  assign consume = ((state_q == StWaitT0) || (state_q == StWaitT1)) && play_i && tick_pending;
  assign restart_addr = dir_i ? END_ADDR : START_ADDR;

  tick_latch u_tick_latch (
    .clk        (clk),
    .rst        (rst),
    .tick_i     (sample_tick_i),
    .play_i     (play_i),
    .consume_i  (consume),
    .clear_i    (restart_i),
    .pending_o  (tick_pending),
    .underrun_o (underrun_o)
  );

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    word_d         = word_q;
    wdir_d         = wdir_q;
    restart_pend_d = restart_pend_q | restart_i;
    audio_d        = audio_q;
    audio_valid_d  = 1'b0;
    case (state_q)
      StIdle: begin
        restart_pend_d = 1'b0;
        if (restart_i) begin
          addr_d = restart_addr;
        end
        if (play_i) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (!flash_waitrequest_i) begin
          state_d = StWaitData;
        end
      end
      StWaitData: begin
        if (flash_readdatavalid_i) begin
          word_d  = flash_readdata_i;
          wdir_d  = dir_i;
          state_d = StWaitT0;
        end
      end
      // Samples are loaded on the consuming edge so the registered outputs line up with OUTx.
      StWaitT0: begin
        if (consume) begin
          audio_d       = wdir_q ? word_q[31:16] : word_q[15:0];
          audio_valid_d = 1'b1;
          state_d       = StOut0;
        end
      end
      StOut0: state_d = StWaitT1;
      StWaitT1: begin
        if (consume) begin
          audio_d       = wdir_q ? word_q[15:0] : word_q[31:16];
          audio_valid_d = 1'b1;
          state_d       = StOut1;
        end
      end
      StOut1: state_d = StAdvance;
      StAdvance: begin
        restart_pend_d = 1'b0;
        if (restart_pend_q || restart_i) begin
          addr_d = restart_addr;
        end else if (!dir_i) begin
          addr_d = (addr_q == END_ADDR) ? START_ADDR : addr_q + ADDR_W'(1);
        end else begin
          addr_d = (addr_q == START_ADDR) ? END_ADDR : addr_q - ADDR_W'(1);
        end
        state_d = play_i ? StReq : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      addr_q         <= START_ADDR;
      word_q         <= '0;
      wdir_q         <= 1'b0;
      restart_pend_q <= 1'b0;
      flash_read_q   <= 1'b0;
      audio_q        <= '0;
      audio_valid_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      word_q         <= word_d;
      wdir_q         <= wdir_d;
      restart_pend_q <= restart_pend_d;
      flash_read_q   <= (state_d == StReq);
      audio_q        <= audio_d;
      audio_valid_q  <= audio_valid_d;
    end
  end

  assign flash_addr_o  = addr_q;
  assign flash_read_o  = flash_read_q;
  assign audio_out_o   = audio_q;
  assign audio_valid_o = audio_valid_q;
  assign state_dbg_o   = state_q;

endmodule
